muldiv_sched: RTL and testbench
===============================

// Module: muldiv_sched
// PURPOSE
//  Schedules the single shared multi-cycle multiply/divide unit between the two issue lanes
//  (lane A = older, lane B = younger) in the E stage. Grants in program order, times the
//  operation, pulses the HI/LO write, and raises per-lane stall requests to the hazard logic
//  for mult/div structural conflicts and mfhi/mflo reads of a pending result.
// PARAMETERS
//  MUL_CYCLES  4   cycles from start to HI/LO write for mult/multu (legal range >=2)
//  DIV_CYCLES  32  cycles from start to HI/LO write for div/divu (legal range >=2)
//  CW          6   cycle-counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//  clk      in   1  clock, all state on rising edge
//  reset    in   1  synchronous, active-low reset
//  reqa     in   1  lane A has mult/div in E stage
//  opa      in   2  lane A op: 00 mult, 01 multu, 10 div, 11 divu
//  reqb     in   1  lane B has mult/div in E stage
//  opb      in   2  lane B op, encoding as opa
//  hilorda  in   1  lane A has mfhi/mflo in D stage
//  hilordb  in   1  lane B has mfhi/mflo in D stage
//  flushe   in   1  E stage squashed this cycle
//  granta   out  1  lane A op accepted this cycle
//  grantb   out  1  lane B op accepted this cycle
//  start    out  1  one-cycle start pulse to mult/div unit
//  op       out  2  op presented to unit; valid while start=1
//  srcsel   out  1  operand select: 0 lane A, 1 lane B; valid while start=1
//  hilowe   out  1  one-cycle HI/LO register write enable
//  busy     out  1  unit occupied (state RUN or WB)
//  stalla   out  1  stall request for lane A
//  stallb   out  1  stall request for lane B
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): state IDLE, counter 0; all outputs 0 next cycle. Reset
//    mid-operation abandons the op: no hilowe is ever issued for it.
//  - FSM IDLE -> RUN -> WB -> IDLE. busy = (state != IDLE).
//  - IDLE: if flushe=1, no grant. Else reqa=1 -> granta; else reqb=1 -> grantb. Grant
//    cycle T: start=1, op/srcsel from granted lane, counter <= N-1 (N per op), -> RUN.
//    Grants/start are combinational in the grant cycle.
//  - RUN: counter decrements each cycle; at counter==1 -> WB. WB: hilowe=1 at T+N exactly,
//    -> IDLE. flushe during RUN/WB has no effect (op already committed).
//  - Only one grant per cycle; reqa and reqb together in IDLE -> A granted, B stalled.
//  - stalla = reqa & (state != IDLE)  |  hilorda & (busy | start).
//  - stallb = stalla | reqb & (busy | reqa) | hilordb & (busy | start).
//    (B never passes a stalled A; B mfhi/mflo behind a same-cycle start waits for result.)
//  - Requests in WB cycle are stalled and granted next cycle (IDLE) unless feature enabled.
//  - Counter arithmetic unsigned, CW bits; no wrap occurs for legal parameters.
// CONFIGURATION
//  MULDIV_BACKTOBACK_EN defined: in WB, a pending request (A priority, flushe=0) is
//    granted in the same cycle as hilowe; start=1, counter reloaded, WB -> RUN directly;
//    stall terms use (state==RUN | WB with no grant to that lane) in place of busy.
//  Not defined: WB never grants; one idle cycle between consecutive ops.
// TESTING
//  1 reset=0 two cycles with reqa=1 -> all outputs 0, no start; release -> grant next cycle.
//  2 reqa=1,opa=00 at T -> granta=start=1,srcsel=0 at T; busy T+1..T+4; hilowe only at T+4.
//  3 reqa=1,opa=10 and reqb=1,opb=00 at T -> granta at T, stallb=1 T..T+32, grantb at T+33
//    (T+32 with MULDIV_BACKTOBACK_EN), hilowe at T+32 and T+37.
//  4 start mult at T, hilordb=1 from T -> stallb=1 T..T+4, drops at T+5 (IDLE).
//  5 reqa=1, flushe=1 in IDLE -> granta=0, start=0, state stays IDLE.
//  6 div started at T, reset=0 at T+2 -> outputs 0 from T+3, hilowe never asserted.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched
//   Arbitrates the single shared multi-cycle multiply/divide unit between two issue
//   lanes in the E stage. Lane A is older than lane B, so A always wins a tie.
//   The block grants one op at a time, starts the unit, and times the operation so
//   the HI/LO write enable pulses exactly N cycles after the start. It also raises
//   per-lane stall requests for structural conflicts and for mfhi/mflo reads that
//   would see a stale HI/LO.
//
// Optional feature macro: MULDIV_BACKTOBACK_EN
//   When defined, a pending request can be granted in the write-back cycle, so that
//   consecutive operations run with no idle cycle between them. When undefined, the
//   unit always spends one cycle in IDLE between operations.
//
// Parameters
//   MUL_CYCLES  cycles from start to HI/LO write for mult/multu (>= 2)
//   DIV_CYCLES  cycles from start to HI/LO write for div/divu (>= 2)
//   CW          cycle counter width, holds max(MUL_CYCLES, DIV_CYCLES) - 1
//
// Ports
//   clk      in   clock, all state on rising edge
//   reset    in   synchronous active-low reset
//   reqa     in   lane A has mult/div in E stage
//   opa      in   lane A op: 00 mult, 01 multu, 10 div, 11 divu
//   reqb     in   lane B has mult/div in E stage
//   opb      in   lane B op, same encoding
//   hilorda  in   lane A has mfhi/mflo in D stage
//   hilordb  in   lane B has mfhi/mflo in D stage
//   flushe   in   E stage squashed this cycle
//   granta   out  lane A op accepted this cycle
//   grantb   out  lane B op accepted this cycle
//   start    out  one-cycle start pulse to the unit
//   op       out  op presented to the unit, valid while start=1
//   srcsel   out  operand select (0 lane A, 1 lane B), valid while start=1
//   hilowe   out  one-cycle HI/LO write enable
//   busy     out  unit occupied (RUN or WB)
//   stalla   out  stall request for lane A
//   stallb   out  stall request for lane B

module muldiv_sched #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqa,
  input  logic [1:0] opa,
  input  logic       reqb,
  input  logic [1:0] opb,
  input  logic       hilorda,
  input  logic       hilordb,
  input  logic       flushe,
  output logic       granta,
  output logic       grantb,
  output logic       start,
  output logic [1:0] op,
  output logic       srcsel,
  output logic       hilowe,
  output logic       busy,
  output logic       stalla,
  output logic       stallb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  // The counter is loaded with N-1 at the grant edge and moves to WB when it reads 1,
  // which puts the WB cycle (and hilowe) exactly N cycles after the start pulse.
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nextCount;

  logic          w_canGrant;
  logic          w_grantA;
  logic          w_grantB;
  logic          w_start;
  logic [1:0]    w_op;
  logic          w_hilowe;
  logic          w_busy;
  logic          w_occA;
  logic          w_occB;

  // State and cycle counter. A reset during an operation simply drops it: the
  // state returns to IDLE so the WB cycle that would write HI/LO never happens.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Next-state, grant and start logic. Grants are combinational so the unit
  // starts in the same cycle the op is accepted. Grants and the HI/LO write are
  // held off while reset is asserted, so nothing leaks out during reset.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_canGrant  = 1'b0;
    w_grantA    = 1'b0;
    w_grantB    = 1'b0;
    w_hilowe    = 1'b0;

    case (r_state)
      IDLE: begin
        w_canGrant = 1'b1;
      end
      RUN: begin
        w_nextCount = r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          w_nextState = WB;
        end
      end
      WB: begin
        w_hilowe    = reset;
        w_nextState = IDLE;
`ifdef MULDIV_BACKTOBACK_EN
        w_canGrant  = 1'b1;
`endif
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_canGrant && reset && !flushe) begin
      if (reqa) begin
        w_grantA = 1'b1;
      end else if (reqb) begin
        w_grantB = 1'b1;
      end
    end

    w_start = w_grantA | w_grantB;
    w_op    = w_grantA ? opa : (w_grantB ? opb : 2'b00);

    if (w_start) begin
      w_nextState = RUN;
      w_nextCount = w_op[1] ? DIV_LOAD : MUL_LOAD;
    end
  end

  assign w_busy = (r_state != IDLE);

  // Per-lane occupancy seen by the stall terms. With back-to-back issue, a lane
  // that is granted in the WB cycle must not also be told to stall.
`ifdef MULDIV_BACKTOBACK_EN
  assign w_occA = (r_state == RUN) | ((r_state == WB) & !w_grantA);
  assign w_occB = (r_state == RUN) | ((r_state == WB) & !w_grantB);
`else
  assign w_occA = w_busy;
  assign w_occB = w_busy;
`endif

  // Lane B includes lane A's stall so it can never overtake a stalled older op,
  // and an mfhi/mflo behind a same-cycle start waits for the new result.
  assign stalla = (reqa & w_occA) | (hilorda & (w_occA | w_start));
  assign stallb = stalla | (reqb & (w_occB | reqa)) | (hilordb & (w_occB | w_start));

  assign granta = w_grantA;
  assign grantb = w_grantB;
  assign start  = w_start;
  assign op     = w_op;
  assign srcsel = w_grantB;
  assign hilowe = w_hilowe;
  assign busy   = w_busy;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched
//   Directed bench for muldiv_sched with default parameters (mult 4 cycles, div 32).
//   Inputs change just after the falling edge; outputs are sampled 1 time unit later,
//   well away from the rising edge. All outputs are packed into one vector
//   {granta, grantb, start, op[1:0], srcsel, hilowe, busy, stalla, stallb}
//   and compared against hand-derived expected vectors.

module tb_muldiv_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqa;
  logic [1:0] opa;
  logic       reqb;
  logic [1:0] opb;
  logic       hilorda;
  logic       hilordb;
  logic       flushe;
  logic       granta;
  logic       grantb;
  logic       start;
  logic [1:0] op;
  logic       srcsel;
  logic       hilowe;
  logic       busy;
  logic       stalla;
  logic       stallb;

  logic [9:0] obsVec;
  int         checks   = 0;
  int         failures = 0;
  logic       sawActivity;

  always #5 clk = ~clk;

  muldiv_sched dut (
    .clk     (clk),
    .reset   (reset),
    .reqa    (reqa),
    .opa     (opa),
    .reqb    (reqb),
    .opb     (opb),
    .hilorda (hilorda),
    .hilordb (hilordb),
    .flushe  (flushe),
    .granta  (granta),
    .grantb  (grantb),
    .start   (start),
    .op      (op),
    .srcsel  (srcsel),
    .hilowe  (hilowe),
    .busy    (busy),
    .stalla  (stalla),
    .stallb  (stallb)
  );

  assign obsVec = {granta, grantb, start, op, srcsel, hilowe, busy, stalla, stallb};

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Builds an expected output vector from individual fields.
  function automatic logic [9:0] mk(input logic ga, input logic gb, input logic st,
                                    input logic [1:0] o, input logic ss, input logic hw,
                                    input logic bz, input logic sa, input logic sb);
    return {ga, gb, st, o, ss, hw, bz, sa, sb};
  endfunction

  // Drives all lane inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic ra, input logic [1:0] oa, input logic rb,
                               input logic [1:0] ob, input logic ha, input logic hb,
                               input logic fl);
    reqa    = ra;
    opa     = oa;
    reqb    = rb;
    opb     = ob;
    hilorda = ha;
    hilordb = hb;
    flushe  = fl;
    #1;
  endtask

  // Advances one clock and returns just after the next falling edge.
  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] muldiv_sched directed test start");
    reset = 1'b0;
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with reqa=1: nothing granted, all outputs low.
    nextCycle();
    checkOutput("reset_c1", obsVec, 10'b0);
    nextCycle();
    checkOutput("reset_c2", obsVec, 10'b0);

    // Release reset with reqa=1, mult: granted immediately, lane A operands.
    reset = 1'b1;
    #1;
    checkOutput("mult_grant", obsVec, mk(1, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("mult_t%0d", k), obsVec,
                  mk(0, 0, 0, 2'b00, 0, (k == 4), (k <= 4), 0, 0));
      nextCycle();
    end

    // Flushed request in IDLE: no grant, state stays IDLE.
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_nogrant", obsVec, 10'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_idle", obsVec, 10'b0);

    // A div and B mult together: A wins, B stalls through the div, then runs.
    applyStimulus(1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("dual_grantA", obsVec, mk(1, 0, 1, 2'b10, 0, 0, 0, 0, 1));
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      checkOutput($sformatf("dual_run_t%0d", k), obsVec, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 1));
      nextCycle();
    end
`ifdef MULDIV_BACKTOBACK_EN
    checkOutput("dual_wb_t32", obsVec, mk(0, 1, 1, 2'b00, 1, 1, 1, 0, 0));
    nextCycle();
`else
    checkOutput("dual_wb_t32", obsVec, mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 1));
    nextCycle();
    checkOutput("dual_grantB_t33", obsVec, mk(0, 1, 1, 2'b00, 1, 0, 0, 0, 0));
    nextCycle();
`endif
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("dual_multB_t%0d", k), obsVec,
                  mk(0, 0, 0, 2'b00, 0, (k == 4), (k <= 4), 0, 0));
      nextCycle();
    end

    // mfhi in lane B behind a same-cycle mult start waits for the result.
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("hilo_start", obsVec, mk(1, 0, 1, 2'b00, 0, 0, 0, 0, 1));
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("hilo_t%0d", k), obsVec,
                  mk(0, 0, 0, 2'b00, 0, (k == 4), (k <= 4), 0, (k <= 4)));
      nextCycle();
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Div started, reset asserted two cycles later: op abandoned, no HI/LO write.
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_grant", obsVec, mk(1, 0, 1, 2'b11, 0, 0, 0, 0, 0));
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_t1", obsVec, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0));
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("abort_t2", obsVec, mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0));
    nextCycle();
    checkOutput("abort_t3", obsVec, 10'b0);
    reset = 1'b1;
    sawActivity = 1'b0;
    for (int k = 0; k < 40; k++) begin
      nextCycle();
      sawActivity = sawActivity | hilowe | busy;
    end
    checkOutput("abort_no_hilowe", {9'b0, sawActivity}, 10'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
